if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register.
- Holds the PC, drives the instruction-memory address and selects the next PC from sequential, jump (from ID) or taken-branch (from a later stage) sources.
- Registers the fetched instruction and PC+4 into IF/ID for the decode stage.
- Obeys the hazard unit's PC/IF-ID write enables and the controller's flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on flush or reset.

Ports:
- Clock  in  1  system clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- PC_WriteEnable  in  1  hazard unit; 0 holds the PC (load-use stall).
- IFID_WriteEnable  in  1  hazard unit; 0 holds the IF/ID contents.
- IFID_Flush  in  1  decode controller; jump in ID, squash the fetched instruction.
- Jump  in  1  decode controller; redirect the PC to JumpDest.
- JumpDest  in  32  jump target computed in decode (J/JAL or JR).
- BranchTaken  in  1  resolved taken branch from a later stage.
- BranchDest  in  32  branch target.
- IM_Address  out  32  instruction-memory address (current PC).
- IM_Data  in  32  instruction word; combinational read of IM_Address.
- PC_Out  out  32  current PC register value.
- IFID_Instruction  out  32  registered instruction to decode.
- IFID_PC  out  32  registered PC+4 of that instruction.
- IFID_Valid  out  1  1 = IF/ID holds a real fetched instruction.

Behaviour:
- Reset, checked at the clock edge and taking priority over everything:
  - PC <= RESET_PC.
  - IFID_Instruction <= NOP_INSTR, IFID_PC <= 0, IFID_Valid <= 0.
- IM_Address = PC_Out = PC, combinational. IM_Data is sampled in the same cycle. Fetch-to-IF/ID latency is 1 cycle.
- PC+4 is a 32-bit add that wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0). No alignment check; the low 2 bits of a target are carried through unchanged.
- Next-PC priority, highest first:
  1. BranchTaken = 1: PC <= BranchDest. This applies even when PC_WriteEnable = 0, because the older branch overrides the stall.
  2. PC_WriteEnable = 0: PC holds.
  3. Jump = 1: PC <= JumpDest.
  4. Otherwise: PC <= PC+4.
- IF/ID update priority, highest first:
  1. BranchTaken = 1: load NOP_INSTR, IFID_PC <= 0, Valid <= 0. This overrides IFID_WriteEnable = 0.
  2. IFID_WriteEnable = 0: hold all IF/ID fields, Valid included.
  3. IFID_Flush = 1: load NOP_INSTR, IFID_PC <= 0, Valid <= 0.
  4. Otherwise: IFID_Instruction <= IM_Data, IFID_PC <= PC+4, Valid <= 1.
- Jump together with PC_WriteEnable = 0: the jump is ignored this cycle. The ID instruction is held, so Jump reasserts next cycle.
- Jump and BranchTaken in the same cycle: the branch wins and the jump is discarded, since the jumping instruction is squashed.
- Reset asserted mid-stall or mid-redirect: reset values apply at that edge. The first fetch from RESET_PC enters IF/ID on the first edge after Reset deasserts.
- No internal FSM beyond the PC register and IF/ID register. The stage is a 2-register pipeline front end with a priority next-PC mux.

Decomposition:
- Shared pipeline package holds:
  - NOP_INSTR and RESET_PC defaults.
  - PC_INCR = 4.
  - Next-PC select encoding: SEL_SEQ, SEL_JUMP, SEL_BRANCH, SEL_HOLD. This encoding is reused by the hazard/branch logic.
- One natural sub-module, ifid_register: enable, flush and reset for the instruction/PC/valid triple.
- The PC register and next-PC mux stay in if_stage.

Test Plan:
- Reset 2 cycles, then release; IM_Data = mem[addr>>2] with mem[i] = 32'hA000_0000+i. Expected: PC 0,4,8,12; IFID_Instruction A000_0000, A000_0001, ... one cycle later; IFID_PC 4,8,12; Valid 0 then 1.
- Stall at PC = 8: PC_WriteEnable = 0 and IFID_WriteEnable = 0 for 2 cycles. Expected: PC stays 8, IF/ID stays A000_0001 / 8; sequential fetch resumes at 8 after release.
- Jump: Jump = 1, IFID_Flush = 1, JumpDest = 32'h40 while PC = 12. Expected next cycle: PC = 0x40, IF/ID = NOP with Valid 0; the following cycle IF/ID = A000_0010 / 0x44.
- BranchTaken = 1, BranchDest = 32'h100 while PC_WriteEnable = 0, IFID_WriteEnable = 0 and Jump = 1. Expected: PC = 0x100, IF/ID = NOP, Valid 0 (branch beats stall and jump).
- Wrap: branch to 32'hFFFF_FFFC. Expected: next PC = 0, IFID_PC = 0 for that instruction.
- Reset asserted while BranchTaken = 1. Expected: PC = RESET_PC, IF/ID = NOP, Valid 0.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions: reset/NOP defaults, PC increment and the
// next-PC select encoding used by the fetch stage and hazard/branch logic.
package if_stage_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INCR           = 32'd4;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_JUMP   = 2'd1,
    SEL_BRANCH = 2'd2,
    SEL_HOLD   = 2'd3
  } pc_sel_e;

  // Sequential successor of a PC; the add wraps modulo 2^32.
  function automatic logic [31:0] pc_plus_incr(input logic [31:0] pc);
    return pc + PC_INCR;
  endfunction

endpackage

// File: rtl/if_stage_ifid_register.sv
// IF/ID pipeline register: instruction, PC+4 and valid flag with reset,
// squash (overrides the write enable), write enable and flush.
module ifid_register
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        squash,
  input  logic        write_enable,
  input  logic        flush,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        valid
);

  logic [31:0] instr_r;
  logic [31:0] pc_r;
  logic        valid_r;

  // Priority update: reset, squash from a taken branch, stall hold, flush, load.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_r <= NOP_INSTR;
      pc_r    <= 32'h0000_0000;
      valid_r <= 1'b0;
    end else if (squash) begin
      instr_r <= NOP_INSTR;
      pc_r    <= 32'h0000_0000;
      valid_r <= 1'b0;
    end else if (!write_enable) begin
      instr_r <= instr_r;
      pc_r    <= pc_r;
      valid_r <= valid_r;
    end else if (flush) begin
      instr_r <= NOP_INSTR;
      pc_r    <= 32'h0000_0000;
      valid_r <= 1'b0;
    end else begin
      instr_r <= instr_in;
      pc_r    <= pc_in;
      valid_r <= 1'b1;
    end
  end

  assign instr = instr_r;
  assign pc    = pc_r;
  assign valid = valid_r;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, priority next-PC mux and the IF/ID
// pipeline register feeding decode.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        PC_WriteEnable,
  input  logic        IFID_WriteEnable,
  input  logic        IFID_Flush,
  input  logic        Jump,
  input  logic [31:0] JumpDest,
  input  logic        BranchTaken,
  input  logic [31:0] BranchDest,
  output logic [31:0] IM_Address,
  input  logic [31:0] IM_Data,
  output logic [31:0] PC_Out,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PC,
  output logic        IFID_Valid
);

  logic [31:0] pc_r;
  logic [31:0] pc_seq_s;
  logic [31:0] pc_next_s;
  pc_sel_e     pc_sel_s;

  assign pc_seq_s = pc_plus_incr(pc_r);

  // Next-PC source select: an older taken branch beats the stall, the stall beats a jump.
  always_comb begin
    pc_sel_s = SEL_SEQ;
    if (BranchTaken) begin
      pc_sel_s = SEL_BRANCH;
    end else if (!PC_WriteEnable) begin
      pc_sel_s = SEL_HOLD;
    end else if (Jump) begin
      pc_sel_s = SEL_JUMP;
    end else begin
      pc_sel_s = SEL_SEQ;
    end
  end

  // Next-PC mux driven by the select encoding; targets pass through unaligned.
  always_comb begin
    pc_next_s = pc_seq_s;
    case (pc_sel_s)
      SEL_SEQ:    pc_next_s = pc_seq_s;
      SEL_JUMP:   pc_next_s = JumpDest;
      SEL_BRANCH: pc_next_s = BranchDest;
      SEL_HOLD:   pc_next_s = pc_r;
      default:    pc_next_s = pc_r;
    endcase
  end

  // PC register with synchronous reset to the boot address.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  assign IM_Address = pc_r;
  assign PC_Out     = pc_r;

  ifid_register #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid (
    .clk          (Clock),
    .reset        (Reset),
    .squash       (BranchTaken),
    .write_enable (IFID_WriteEnable),
    .flush        (IFID_Flush),
    .instr_in     (IM_Data),
    .pc_in        (pc_seq_s),
    .instr        (IFID_Instruction),
    .pc           (IFID_PC),
    .valid        (IFID_Valid)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for if_stage with a synthetic instruction
// memory mem[i] = 32'hA000_0000 + i.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        pc_we;
  logic        ifid_we;
  logic        ifid_flush;
  logic        jump;
  logic [31:0] jump_dest;
  logic        branch;
  logic [31:0] branch_dest;
  logic [31:0] im_address;
  logic [31:0] im_data;
  logic [31:0] pc_out;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic        ifid_valid;

  int checks;
  int failures;

  typedef struct {
    logic        rst;
    logic        pwe;
    logic        iwe;
    logic        fl;
    logic        jmp;
    logic [31:0] jd;
    logic        br;
    logic [31:0] bd;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_ifpc;
    logic        e_valid;
  } vec_t;

  vec_t vecs [0:19];

  if_stage dut (
    .Clock            (clk),
    .Reset            (reset),
    .PC_WriteEnable   (pc_we),
    .IFID_WriteEnable (ifid_we),
    .IFID_Flush       (ifid_flush),
    .Jump             (jump),
    .JumpDest         (jump_dest),
    .BranchTaken      (branch),
    .BranchDest       (branch_dest),
    .IM_Address       (im_address),
    .IM_Data          (im_data),
    .PC_Out           (pc_out),
    .IFID_Instruction (ifid_instr),
    .IFID_PC          (ifid_pc),
    .IFID_Valid       (ifid_valid)
  );

  // Combinational instruction memory model.
  assign im_data = 32'hA000_0000 + {2'b00, im_address[31:2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic pwe, input logic iwe,
                              input logic fl, input logic jmp, input logic [31:0] jd,
                              input logic br, input logic [31:0] bd,
                              input logic [31:0] e_pc, input logic [31:0] e_instr,
                              input logic [31:0] e_ifpc, input logic e_valid);
    vec_t v;
    v.rst = rst; v.pwe = pwe; v.iwe = iwe; v.fl = fl; v.jmp = jmp; v.jd = jd;
    v.br = br; v.bd = bd; v.e_pc = e_pc; v.e_instr = e_instr; v.e_ifpc = e_ifpc;
    v.e_valid = e_valid;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic pwe, input logic iwe, input logic fl,
                       input logic jmp, input logic [31:0] jd, input logic br,
                       input logic [31:0] bd);
    reset = rst; pc_we = pwe; ifid_we = iwe; ifid_flush = fl;
    jump = jmp; jump_dest = jd; branch = br; branch_dest = bd;
  endtask

  task automatic check_state(input string tag, input logic [31:0] e_pc,
                             input logic [31:0] e_instr, input logic [31:0] e_ifpc,
                             input logic e_valid);
    check({tag, " pc"}, pc_out, e_pc);
    check({tag, " im_addr"}, im_address, e_pc);
    check({tag, " ifid_instr"}, ifid_instr, e_instr);
    check({tag, " ifid_pc"}, ifid_pc, e_ifpc);
    check({tag, " ifid_valid"}, {31'd0, ifid_valid}, {31'd0, e_valid});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    //          rst  pwe  iwe  fl   jmp  jd            br   bd            e_pc          e_instr       e_ifpc        v
    vecs[0]  = mk(1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0,        32'h0,        32'h0,        1'b0);
    vecs[1]  = mk(1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0,        32'h0,        32'h0,        1'b0);
    vecs[2]  = mk(1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h4,        32'hA000_0000,32'h4,        1'b1);
    vecs[3]  = mk(1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h8,        32'hA000_0001,32'h8,        1'b1);
    vecs[4]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h8,        32'hA000_0001,32'h8,        1'b1);
    vecs[5]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h8,        32'hA000_0001,32'h8,        1'b1);
    vecs[6]  = mk(1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'hC,        32'hA000_0002,32'hC,        1'b1);
    vecs[7]  = mk(1'b0,1'b1,1'b1,1'b1,1'b1,32'h40,       1'b0,32'h0,        32'h40,       32'h0,        32'h0,        1'b0);
    vecs[8]  = mk(1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h44,       32'hA000_0010,32'h44,       1'b1);
    vecs[9]  = mk(1'b0,1'b0,1'b0,1'b0,1'b1,32'h200,      1'b1,32'h100,      32'h100,      32'h0,        32'h0,        1'b0);
    vecs[10] = mk(1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h104,      32'hA000_0040,32'h104,      1'b1);
    vecs[11] = mk(1'b0,1'b1,1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        32'h108,      32'h0,        32'h0,        1'b0);
    vecs[12] = mk(1'b0,1'b0,1'b0,1'b1,1'b1,32'h300,      1'b0,32'h0,        32'h108,      32'h0,        32'h0,        1'b0);
    vecs[13] = mk(1'b0,1'b1,1'b1,1'b1,1'b1,32'h301,      1'b0,32'h0,        32'h301,      32'h0,        32'h0,        1'b0);
    vecs[14] = mk(1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h305,      32'hA000_00C0,32'h305,      1'b1);
    vecs[15] = mk(1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,        1'b1,32'hFFFF_FFFC,32'hFFFF_FFFC,32'h0,        32'h0,        1'b0);
    vecs[16] = mk(1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0,        32'hDFFF_FFFF,32'h0,        1'b1);
    vecs[17] = mk(1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h4,        32'hDFFF_FFFF,32'h0,        1'b1);
    vecs[18] = mk(1'b1,1'b0,1'b0,1'b0,1'b1,32'h500,      1'b1,32'h80,       32'h0,        32'h0,        32'h0,        1'b0);
    vecs[19] = mk(1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h4,        32'hA000_0000,32'h4,        1'b1);

    #1;
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].rst, vecs[i].pwe, vecs[i].iwe, vecs[i].fl,
            vecs[i].jmp, vecs[i].jd, vecs[i].br, vecs[i].bd);
      @(posedge clk);
      #1;
      check_state($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr,
                  vecs[i].e_ifpc, vecs[i].e_valid);
    end

    // Jump held across a two-cycle stall: ignored while stalled, taken once released.
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 1'b0, 32'h0);
      @(posedge clk);
      #1;
      check_state($sformatf("stalljump%0d", k), 32'h4, 32'hA000_0000, 32'h4, 1'b1);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h20, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    check_state("jumprelease", 32'h20, 32'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    check_state("jumpfetch", 32'h24, 32'hA000_0008, 32'h24, 1'b1);

    // Back-to-back branches: the second squashes the first target's fetch.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200);
    @(posedge clk);
    #1;
    check_state("br1", 32'h200, 32'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10);
    @(posedge clk);
    #1;
    check_state("br2", 32'h10, 32'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    check_state("br2fetch", 32'h14, 32'hA000_0004, 32'h14, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
